// File: rtl/ps2_kb_rx_if.sv
// Byte handshake between the PS/2 receiver FIFO and the keyboard/screen driver.
// The receiver is the master: it presents the head byte and request, the driver returns the accept strobe.
interface ps2_kb_rx_if;
    logic [7:0] data_o;
    logic       wr_req_o;
    logic       wr_ack_n_i;

    modport master (output data_o, output wr_req_o, input wr_ack_n_i);
    modport slave  (input data_o, input wr_req_o, output wr_ack_n_i);
endinterface

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronise and filter the lines, decode 11-bit frames,
// and buffer good bytes in a small FIFO drained through an active-low accept strobe.
module ps2_kb_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    ps2_kb_rx_if.master                   wr_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          ovf_clr_i
);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 = PS/2 clock, index 1 = PS/2 data
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d, flt_q, flt_d;
    logic [FLT_W-1:0] fcnt_q [2];
    logic [FLT_W-1:0] fcnt_d [2];
    logic             clk_prev_q, clk_prev_d;
    logic             fe, dbit;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             push_q, push_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, pop, wr, drop;

    always_comb begin
        sync1_d    = {ps2_data_i, ps2_clk_i};
        sync2_d    = sync1_q;
        flt_d      = flt_q;
        clk_prev_d = flt_q[0];
        for (int unsigned i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync2_q[i] != flt_q[i]) begin
                if (fcnt_q[i] == FLT_LAST) flt_d[i] = sync2_q[i];
                else                       fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    assign fe   = clk_prev_q & ~flt_q[0];
    assign dbit = flt_q[1];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = tmo_q + 1'b1;
        err_d     = 1'b0;
        push_d    = 1'b0;
        if (state_q == IDLE || fe) tmo_d = '0;
        if (fe) begin
            case (state_q)
                IDLE: begin
                    if (!dbit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d[bit_cnt_q] = dbit;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 1'b1;
                end
                PARITY: begin
                    par_d   = dbit;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dbit && (^{shreg_q, par_q})) push_d = 1'b1;
                    else                             err_d  = 1'b1;
                end
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    // shreg_q stays untouched in IDLE, so the pushed byte is read straight from it
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_FULL);
        pop      = !empty && !wr_if.wr_ack_n_i;
        wr       = push_q && (!full || pop);
        drop     = push_q && full && !pop;
        mem_d    = mem_q;
        if (wr) mem_d[wr_ptr_q] = shreg_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = drop | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            flt_q      <= '1;
            fcnt_q     <= '{default: '0};
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            push_q     <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            flt_q      <= flt_d;
            fcnt_q     <= fcnt_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            push_q     <= push_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign wr_if.wr_req_o = !empty;
    assign wr_if.data_o   = mem_q[rd_ptr_q];
    assign fifo_count_o   = count_q;
    assign frame_err_o    = err_q;
    assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_ps2_kb_rx.sv
// Randomized frame bench for ps2_kb_rx against a queue-based reference model of the
// receiver's byte stream, error pulses and overflow flag.
module tb_ps2_kb_rx;
    localparam int unsigned FLT   = 8;
    localparam int unsigned TMO   = 1000;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HALF  = 20;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, ovf_clr, frame_err, ovf;
    logic [2:0] cnt;

    ps2_kb_rx_if bus ();

    ps2_kb_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .wr_if        (bus.master),
        .fifo_count_o (cnt),
        .frame_err_o  (frame_err),
        .overflow_o   (ovf),
        .ovf_clr_i    (ovf_clr)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    bit          ovf_exp = 1'b0;
    byte unsigned q[$];

    always @(negedge clk) if (frame_err) err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, " count"}, 32'(cnt), 32'(q.size()));
        check({tag, " wr_req"}, 32'(bus.wr_req_o), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, " data"}, 32'(bus.data_o), 32'(q[0]));
        check({tag, " ovf"}, 32'(ovf), 32'(ovf_exp));
        check({tag, " errs"}, 32'(err_seen), 32'(err_exp));
    endtask

    // One PS/2 bit; optionally strobe the accept exactly in the cycle the stop bit's push lands
    task automatic ps2_bit(input bit b, input bit ack_at_push);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        if (ack_at_push) begin
            tick(FLT + 3);
            bus.wr_ack_n_i = 1'b0;
            tick(1);
            bus.wr_ack_n_i = 1'b1;
            tick(HALF - FLT - 4);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input byte unsigned b, input bit bad_par, input bit bad_stop,
                              input bit ack_at_push);
        bit par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(~bad_stop, ack_at_push);
        ps2_data = 1'b1;
        tick(HALF + 10);
        if (bad_par || bad_stop) begin
            err_exp++;
        end else begin
            if (ack_at_push && q.size() != 0) void'(q.pop_front());
            if (q.size() < DEPTH) q.push_back(b);
            else                  ovf_exp = 1'b1;
        end
    endtask

    task automatic ack_pulse(input string tag);
        if (q.size() != 0) check({tag, " head"}, 32'(bus.data_o), 32'(q[0]));
        bus.wr_ack_n_i = 1'b0;
        tick(1);
        bus.wr_ack_n_i = 1'b1;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
    endtask

    task automatic clr_pulse();
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        ovf_exp = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ovf_clr = 1'b0;
        bus.wr_ack_n_i = 1'b1;
        tick(3);
        check("reset count", 32'(cnt), 32'd0);
        check("reset wr_req", 32'(bus.wr_req_o), 32'd0);
        check("reset data", 32'(bus.data_o), 32'd0);
        check("reset err", 32'(frame_err), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick(5);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_state("good 1C");
        check("good 1C byte", 32'(bus.data_o), 32'h1C);
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check_state("bad parity");
        ack_pulse("drain 1C");
        check_state("empty again");

        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i), 1'b0);
        tick(TMO + 50);
        err_exp++;
        check_state("timeout");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_state("after timeout");
        ack_pulse("drain 5A");

        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check_state("overflow");
        for (int i = 0; i < 4; i++) ack_pulse("ordered pop");
        check_state("drained");
        clr_pulse();
        check_state("ovf cleared");

        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
        send_frame(8'h15, 1'b0, 1'b0, 1'b1);
        check_state("push+pop full");
        for (int i = 0; i < 4; i++) ack_pulse("post push+pop");

        ps2_clk = 1'b0;
        tick(FLT - 2);
        ps2_clk = 1'b1;
        tick(40);
        check_state("glitch");
        ack_pulse("ack empty");
        check_state("ack empty");

        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        do_reset();
        tick(5);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        check_state("after mid reset");
        ack_pulse("drain F0");

        for (int it = 0; it < 40; it++) begin
            byte unsigned b;
            bit bp, bs;
            int np;
            b  = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = !bp && ($urandom_range(0, 7) == 0);
            send_frame(b, bp, bs, 1'b0);
            check_state($sformatf("rand %0d", it));
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) ack_pulse("rand pop");
            if ($urandom_range(0, 9) == 0) clr_pulse();
        end
        check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
